// File: rtl/fir_mac_serial.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_serial
// Description : Time-multiplexed FIR multiply-accumulate engine. On each
//               start pulse it walks all taps, forming one coefficient x
//               delay-tap product per cycle. It then emits one scaled,
//               registered result with a single-cycle valid pulse.
//               Optional macro FIR_MAC_SAT_EN clamps the output to OUT_W
//               range and reports clamping on oSat; without it the output
//               wraps and oSat is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_serial #(
    parameter int NUM_TAPS  = 10,
    parameter int COEFF_W   = 16,
    parameter int DATA_W    = 3,
    parameter int ACC_W     = 24,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0,
    localparam int TAP_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic               iClk12M,
    input  logic               iRst,
    input  logic               iEnMul,
    input  logic [COEFF_W-1:0] iCoeff,
    input  logic [DATA_W-1:0]  iTapData,
    output logic [TAP_W-1:0]   oTapSel,
    output logic               oBusy,
    output logic               oValid,
    output logic [OUT_W-1:0]   oMul,
    output logic               oOverrun,
    output logic               oSat
);

    localparam int PROD_W = COEFF_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_start;
    logic                       w_last;
    logic        [TAP_W-1:0]    r_cnt;
    logic signed [PROD_W-1:0]   r_prod;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [COEFF_W-1:0]  w_coeff;
    logic signed [DATA_W-1:0]   w_data;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic        [OUT_W-1:0]    w_out;

    // Full-precision signed product and its accumulator-width extension
    assign w_coeff    = iCoeff;
    assign w_data     = iTapData;
    assign w_prod     = PROD_W'(w_coeff) * PROD_W'(w_data);
    assign w_prod_ext = ACC_W'(r_prod);
    assign w_acc_next = r_acc + w_prod_ext;
    assign w_last     = (r_cnt == TAP_W'(NUM_TAPS - 1));
    assign oTapSel    = (r_state == S_RUN) ? r_cnt : '0;

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] c_OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] w_shifted;
    logic                    w_sat;
    logic                    r_sat;

    // Clamp the scaled sum into the representable output range
    always_comb begin
        w_shifted = w_acc_next >>> OUT_SHIFT;
        w_sat     = 1'b0;
        w_out     = w_shifted[OUT_W-1:0];
        if (w_shifted > c_OUT_MAX) begin
            w_out = c_OUT_MAX[OUT_W-1:0];
            w_sat = 1'b1;
        end else if (w_shifted < c_OUT_MIN) begin
            w_out = c_OUT_MIN[OUT_W-1:0];
            w_sat = 1'b1;
        end
    end

    // Saturation flag is captured together with the result
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            r_sat <= 1'b0;
        end else if (r_state == S_DRAIN) begin
            r_sat <= w_sat;
        end
    end

    assign oSat = r_sat;
`else
    // Two's-complement wrap: keep the low OUT_W bits of the scaled sum
    assign w_out = OUT_W'(w_acc_next >>> OUT_SHIFT);
    assign oSat  = 1'b0;
`endif

    // State register
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status outputs; DONE doubles as a start window
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        oBusy        = 1'b0;
        oValid       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iEnMul) begin
                    w_start      = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                oBusy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                oBusy        = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                oValid = 1'b1;
                if (iEnMul) begin
                    w_start      = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: one product per RUN cycle, the accumulator lags by one
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            r_cnt  <= '0;
            r_prod <= '0;
            r_acc  <= '0;
            oMul   <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (r_state == S_RUN) begin
            r_prod <= w_prod;
            // The product register is stale on the first tap
            if (r_cnt != '0) begin
                r_acc <= w_acc_next;
            end
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end else if (r_state == S_DRAIN) begin
            r_acc <= w_acc_next;
            oMul  <= w_out;
        end
    end

    // Sticky flag for start requests that arrive while busy
    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            oOverrun <= 1'b0;
        end else if (iEnMul && (r_state == S_RUN || r_state == S_DRAIN)) begin
            oOverrun <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac_serial
// Description : Self-checking bench for fir_mac_serial. A coefficient ROM
//               and a delay-line model are driven from arrays indexed by
//               oTapSel; expected results come from a direct dot product.
//               Honours FIR_MAC_SAT_EN for expected clamping.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_serial;

    localparam int NUM_TAPS  = 10;
    localparam int COEFF_W   = 16;
    localparam int DATA_W    = 3;
    localparam int ACC_W     = 24;
    localparam int OUT_W     = 16;
    localparam int OUT_SHIFT = 0;
    localparam int TAP_W     = 4;
    localparam int LATENCY   = NUM_TAPS + 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               en_mul;
    logic [COEFF_W-1:0] coeff;
    logic [DATA_W-1:0]  tap_data;
    logic [TAP_W-1:0]   tap_sel;
    logic               busy;
    logic               valid;
    logic [OUT_W-1:0]   mul;
    logic               overrun;
    logic               sat;

    logic signed [COEFF_W-1:0] coeff_mem [0:15];
    logic signed [DATA_W-1:0]  data_mem  [0:15];

    int n_checks = 0;
    int n_fails  = 0;

    fir_mac_serial #(
        .NUM_TAPS (NUM_TAPS),
        .COEFF_W  (COEFF_W),
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .OUT_W    (OUT_W),
        .OUT_SHIFT(OUT_SHIFT)
    ) u_dut (
        .iClk12M (clk),
        .iRst    (rst),
        .iEnMul  (en_mul),
        .iCoeff  (coeff),
        .iTapData(tap_data),
        .oTapSel (tap_sel),
        .oBusy   (busy),
        .oValid  (valid),
        .oMul    (mul),
        .oOverrun(overrun),
        .oSat    (sat)
    );

    always #5 clk = ~clk;

    // Combinational ROM and delay-line mux seen by the engine
    assign coeff    = coeff_mem[tap_sel];
    assign tap_data = data_mem[tap_sel];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain dot product, scaled, then wrapped or clamped
    task automatic model(output logic [OUT_W-1:0] m, output logic s);
        longint sum;
        longint sh;
        sum = 0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            sum += longint'(coeff_mem[i]) * longint'(data_mem[i]);
        end
        sh = sum >>> OUT_SHIFT;
        m  = sh[OUT_W-1:0];
        s  = 1'b0;
`ifdef FIR_MAC_SAT_EN
        if (sh > 32767) begin
            m = 16'h7FFF;
            s = 1'b1;
        end else if (sh < -32768) begin
            m = 16'h8000;
            s = 1'b1;
        end
`endif
    endtask

    task automatic fill(input logic signed [COEFF_W-1:0] c, input logic signed [DATA_W-1:0] d);
        for (int i = 0; i < 16; i++) begin
            coeff_mem[i] = c;
            data_mem[i]  = d;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            coeff_mem[i] = COEFF_W'($urandom);
            data_mem[i]  = DATA_W'($urandom);
        end
    endtask

    // Called at a negedge: raises the start for this cycle, then follows the
    // run until oValid. inj > 0 pulses iEnMul again in that cycle after start.
    task automatic run_op(input string tag, input int inj);
        int lat;
        int busy_cnt;
        int tap_bad;
        logic [OUT_W-1:0] exp_m;
        logic exp_s;
        model(exp_m, exp_s);
        en_mul   = 1'b1;
        lat      = 0;
        busy_cnt = 0;
        tap_bad  = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            en_mul = (lat == inj);
            if (busy) busy_cnt++;
            if (lat <= NUM_TAPS) begin
                if (tap_sel !== TAP_W'(lat - 1)) tap_bad++;
            end else if (tap_sel !== '0) begin
                tap_bad++;
            end
            if (valid === 1'b1 || lat > 3 * LATENCY) break;
        end
        en_mul = 1'b0;
        check({tag, "_latency"}, lat, LATENCY);
        check({tag, "_busy"}, busy_cnt, NUM_TAPS + 1);
        check({tag, "_tapsel"}, tap_bad, 0);
        check({tag, "_mul"}, mul, exp_m);
        check({tag, "_sat"}, sat, exp_s);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int seen;
        logic [OUT_W-1:0] exp_m;
        logic exp_s;
        en_mul = 1'b0;
        fill(16'sd1, 3'sd1);
        do_reset();

        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mul", mul, 0);
        check("rst_tapsel", tap_sel, 0);
        check("rst_overrun", overrun, 0);
        check("rst_sat", sat, 0);

        // All ones: sum of 10
        run_op("ones", 0);
        check("ones_value", mul, 16'd10);

        // Negative products
        @(negedge clk);
        fill(-16'sd3, 3'sd3);
        run_op("neg", 0);
        check("neg_value", mul, 16'hFFA6);

        // Large sum: wraps or clamps depending on build
        @(negedge clk);
        fill(16'sh7FFF, 3'sd3);
        run_op("big", 0);
`ifdef FIR_MAC_SAT_EN
        check("big_value", mul, 16'h7FFF);
        check("big_satflag", sat, 1);
`else
        check("big_value", mul, 16'hFFE2);
        check("big_satflag", sat, 0);
`endif

        // Back-to-back: restart during the DONE cycle
        @(negedge clk);
        fill_random();
        run_op("b2b_a", 0);
        fill_random();
        run_op("b2b_b", 0);
        check("b2b_overrun", overrun, 0);

        // Start request during RUN cycle 4 is ignored but flagged
        @(negedge clk);
        fill_random();
        run_op("ovr", 4);
        check("ovr_flag", overrun, 1);
        repeat (3) @(negedge clk);
        fill_random();
        run_op("ovr_next", 0);
        check("ovr_sticky", overrun, 1);
        do_reset();
        check("ovr_cleared", overrun, 0);

        // Leave a non-zero result so a mid-run reset has something to clear
        fill(16'sd5, 3'sd1);
        run_op("pre_abort", 0);
        check("pre_abort_value", mul, 16'd50);

        // Reset during RUN cycle 5
        @(negedge clk);
        fill_random();
        en_mul = 1'b1;
        repeat (5) begin
            @(negedge clk);
            en_mul = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_tapsel", tap_sel, 0);
        check("abort_mul", mul, 0);
        seen = 0;
        repeat (2 * LATENCY) begin
            if (valid === 1'b1) seen++;
            @(negedge clk);
        end
        check("abort_novalid", seen, 0);
        run_op("after_abort", 0);

        // Randomized operations with random idle gaps
        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            fill_random();
            if (r == 10) begin
                for (int i = 0; i < NUM_TAPS; i++) begin
                    coeff_mem[i] = -16'sd32768;
                    data_mem[i]  = -3'sd4;
                end
            end
            model(exp_m, exp_s);
            run_op($sformatf("rand%0d", r), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
